// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Snapshots the packed 3x3 product matrix a fixed delay after a start pulse. It then
//   streams the elements out as bytes over valid/ready: element 0 first, and the least
//   significant byte first within each element.
//   Optional build macro: CHECKSUM_EN appends a mod-2^BYTE_W sum byte after the data bytes.
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   start      in   frame request, ignored while busy
//   result     in   ELEM_W*N_ELEMS packed result, element 0 in the low bits
//   out_ready  in   downstream accepts a byte this cycle
//   out_valid  out  out_data holds a valid byte
//   out_data   out  streamed byte
//   out_last   out  marks the final byte of the frame
//   busy       out  high from start acceptance until the final handshake
//   done       out  one-cycle pulse after the final handshake
module matrix_result_streamer #(
  parameter int unsigned ELEM_W        = 16,
  parameter int unsigned N_ELEMS       = 9,
  parameter int unsigned BYTE_W        = 8,
  parameter int unsigned CAPTURE_DELAY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ELEM_W*N_ELEMS-1:0]  result,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [BYTE_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned RES_W   = ELEM_W * N_ELEMS;
  localparam int unsigned N_BYTES = RES_W / BYTE_W;
  localparam int unsigned IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned DLY_W   = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(CAPTURE_DELAY - 1);

`ifdef CHECKSUM_EN
  // The checksum byte carries out_last, so no data byte does.
  localparam logic LAST_ON_DATA = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_CSUM} state_e;
`else
  localparam logic LAST_ON_DATA = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_e;
`endif

  state_e state_q, state_d;

  logic [RES_W-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              out_valid_q, out_valid_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
`endif

  logic hs;
  logic last_data;
  assign hs        = out_valid_q & out_ready;
  assign last_data = (idx_q == LAST_IDX);
  assign idx_nxt   = idx_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: if (dly_q == '0) state_d = S_SEND;
      S_SEND: begin
        if (hs && last_data) begin
`ifdef CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: if (hs) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered below
  always_comb begin
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dly_d  = DLY_LOAD;
          idx_d  = '0;
`ifdef CHECKSUM_EN
          sum_d  = '0;
`endif
        end
      end
      S_WAIT: begin
        if (dly_q == '0) begin
          // The snapshot and the first byte come from the same live sample.
          shadow_d    = result;
          out_valid_d = 1'b1;
          out_data_d  = result[BYTE_W-1:0];
          out_last_d  = LAST_ON_DATA && (LAST_IDX == '0);
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_SEND: begin
        if (hs) begin
`ifdef CHECKSUM_EN
          sum_d = sum_q + out_data_q;
`endif
          if (last_data) begin
`ifdef CHECKSUM_EN
            // The sum register does not yet include the byte being handed off.
            out_data_d = sum_q + out_data_q;
            out_last_d = 1'b1;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
`endif
          end else begin
            idx_d      = idx_nxt;
            out_data_d = shadow_q[32'(idx_nxt) * BYTE_W +: BYTE_W];
            out_last_d = LAST_ON_DATA && (idx_nxt == LAST_IDX);
          end
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      idx_q       <= '0;
      dly_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer
//   Directed bench for matrix_result_streamer at default parameters. It follows the
//   CHECKSUM_EN macro to expect either 18 data bytes or 18 data bytes plus a checksum.
module tb_matrix_result_streamer;

`ifdef CHECKSUM_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [143:0] result;
  logic         out_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  int tests;
  int fails;
  logic [7:0] exp_bytes [0:18];
  logic [143:0] pat;

  matrix_result_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .result    (result),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected bytes for the k*16'h0101 pattern: byte j is j/2.
  task automatic fill_exp_pat();
    for (int j = 0; j < 18; j++) exp_bytes[j] = 8'(j / 2);
    exp_bytes[18] = 8'h48;
  endtask

  task automatic fill_exp_ones();
    for (int j = 0; j < 18; j++) exp_bytes[j] = 8'hFF;
    exp_bytes[18] = 8'hEE;
  endtask

  // Pulse start, then expect busy after the accepting edge and byte 0 one edge later.
  task automatic start_frame(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " valid_in_wait"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " valid_first"}, 32'(out_valid), 32'd1);
    check({tag, " first_byte"}, 32'(out_data), 32'(exp_bytes[0]));
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: ready high, start + result change at byte 5;
  // 3: ready high, stop before handing off byte 9.
  task automatic stream(input string tag, input int mode, output int cycles);
    int n;
    int cyc;
    logic stalled;
    logic [7:0] hd;
    logic hl;
    logic injected;
    n = 0; cyc = 0; stalled = 1'b0; hd = '0; hl = 1'b0; injected = 1'b0;
    while (n < NB && cyc < 300) begin
      if (mode == 3 && n == 9) break;
      out_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (mode == 2 && n == 5 && !injected) begin
        start = 1'b1;
        result = '1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      check({tag, " valid_no_bubble"}, 32'(out_valid), 32'd1);
      if (stalled) begin
        check({tag, " stall_data"}, 32'(out_data), 32'(hd));
        check({tag, " stall_last"}, 32'(out_last), 32'(hl));
      end
      if (out_valid && out_ready) begin
        check($sformatf("%s byte%0d", tag, n), 32'(out_data), 32'(exp_bytes[n]));
        check($sformatf("%s last%0d", tag, n), 32'(out_last), 32'(n == NB - 1));
        n++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        hd = out_data;
        hl = out_last;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    cycles = cyc;
    if (mode != 3) check({tag, " bytes_seen"}, 32'(n), 32'(NB));
  endtask

  task automatic done_now(input string tag);
    check({tag, " done_pulse"}, 32'(done), 32'd1);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " valid_low"}, 32'(out_valid), 32'd0);
    check({tag, " last_low"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    int cycles;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    result = '0;
    pat = '0;
    for (int k = 0; k < 9; k++) pat[k*16 +: 16] = 16'(k * 257);

    // Reset state
    repeat (3) tick();
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst data", 32'(out_data), 32'd0);
    check("rst last", 32'(out_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: full-rate frame
    result = pat;
    fill_exp_pat();
    out_ready = 1'b1;
    start_frame("t1");
    stream("t1", 0, cycles);
    check("t1 cycles", 32'(cycles), 32'(NB));
    done_now("t1");

    // 6: start in the done cycle is accepted
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6 busy", 32'(busy), 32'd1);
    check("t6 done_gone", 32'(done), 32'd0);
    tick();
    check("t6 valid", 32'(out_valid), 32'd1);
    check("t6 first_byte", 32'(out_data), 32'h00);
    stream("t6", 0, cycles);
    done_now("t6");
    tick();
    check("t6 done_one_cycle", 32'(done), 32'd0);

    // 2: backpressure 1,0,0,1
    start_frame("t2");
    stream("t2", 1, cycles);
    done_now("t2");
    tick();
    check("t2 done_one_cycle", 32'(done), 32'd0);

    // 3: start while busy and result change are both ignored
    start_frame("t3");
    stream("t3", 2, cycles);
    done_now("t3");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3 no_second_valid", 32'(out_valid), 32'd0);
      check("t3 no_second_busy", 32'(busy), 32'd0);
    end
    result = pat;

    // 4: reset mid-frame, then a fresh full frame
    start_frame("t4");
    stream("t4a", 3, cycles);
    check("t4 on_byte9", 32'(out_data), 32'(exp_bytes[9]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4 rst_valid", 32'(out_valid), 32'd0);
    check("t4 rst_busy", 32'(busy), 32'd0);
    check("t4 rst_done", 32'(done), 32'd0);
    tick();
    check("t4 idle_valid", 32'(out_valid), 32'd0);
    start_frame("t4b");
    stream("t4b", 0, cycles);
    done_now("t4b");
    tick();

    // 5: all-ones result (checksum 8'hEE when enabled)
    result = '1;
    fill_exp_ones();
    start_frame("t5");
    stream("t5", 0, cycles);
    done_now("t5");
    tick();
    check("t5 done_one_cycle", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
